// File: rtl/ddr_axi_write.sv
// ----------------------------------------------------------------------------
// ddr_axi_write
//   AXI4 write master for the DDR controller path. Accepts one UI write
//   command (start address, beats per burst, number of bursts) and drains a
//   first-word-fall-through write FIFO onto the AXI write channels. Each burst
//   is issued strictly as AW, then all W beats, then B; only one burst is ever
//   in flight, and there is no AW/W overlap.
//
//   Optional feature macro: WR_BRESP_CHECK_EN
//     defined     : wr_err becomes a sticky flag, set by a non-OKAY BRESP and
//                   cleared by reset or by the next accepted command.
//     not defined : wr_err is tied low and BRESP is ignored.
//
// Ports
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   wr_start             command strobe, only looked at while idle
//   wr_burst_len         beats per burst (1..2^BLW-1)
//   wr_start_addr        byte address of the first burst
//   wr_num_burst         bursts per command (1..2^NBW-1)
//   wr_ready             high while idle and able to accept a command
//   wr_fifo_data/empty   FWFT FIFO head and empty flag
//   wr_fifo_re           FIFO pop, asserted on every W handshake
//   wr_done              one-cycle pulse when the whole command has completed
//   wr_err               sticky BRESP error flag (see macro above)
//   m_axi_aw*/w*/b*      AXI4 write address, write data and response channels
// ----------------------------------------------------------------------------
module ddr_axi_write #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 29,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int NUM_BURST_WIDTH = 8
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  // UI command
  input  logic                       wr_start,
  input  logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
  input  logic [ADDR_WIDTH-1:0]      wr_start_addr,
  input  logic [NUM_BURST_WIDTH-1:0] wr_num_burst,
  output logic                       wr_ready,
  // FWFT write FIFO
  input  logic [DATA_WIDTH-1:0]      wr_fifo_data,
  input  logic                       wr_fifo_empty,
  output logic                       wr_fifo_re,
  // status
  output logic                       wr_done,
  output logic                       wr_err,
  // AXI write address channel
  output logic [3:0]                 m_axi_awid,
  output logic [ADDR_WIDTH-1:0]      m_axi_awaddr,
  output logic [BURST_LEN_WIDTH-1:0] m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic                       m_axi_awlock,
  output logic [3:0]                 m_axi_awcache,
  output logic [2:0]                 m_axi_awprot,
  output logic [3:0]                 m_axi_awqos,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  // AXI write data channel
  output logic [DATA_WIDTH-1:0]      m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]    m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  // AXI write response channel
  input  logic [3:0]                 m_axi_bid,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  state_t                     state;
  logic [BURST_LEN_WIDTH-1:0] beat_cnt;
  logic [NUM_BURST_WIDTH-1:0] burst_cnt;
  logic                       start_ok;
  logic                       w_hs;
  logic [ADDR_WIDTH-1:0]      burst_bytes;

  // Fixed AXI attributes: ID 0xF, 8-byte beats, INCR, modifiable/bufferable.
  assign m_axi_awid    = 4'hF;
  assign m_axi_awsize  = 3'b011;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'h0;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = 1'b1;

  // A command with zero beats or zero bursts is dropped while idle.
  assign start_ok = (state == S_IDLE) && wr_start &&
                    (wr_burst_len != '0) && (wr_num_burst != '0);

  // The W channel is a straight pass-through of the FWFT head: data is valid
  // whenever the FIFO is non-empty, and a handshake is exactly a pop.
  assign m_axi_wvalid = (state == S_W) && !wr_fifo_empty;
  assign m_axi_wdata  = wr_fifo_data;
  assign m_axi_wlast  = (state == S_W) && (beat_cnt == m_axi_awlen);
  assign w_hs         = m_axi_wvalid && m_axi_wready;
  assign wr_fifo_re   = w_hs;
  assign wr_ready     = (state == S_IDLE);

  // Address step to the next burst uses the latched length, so the UI inputs
  // may change freely once a command has been accepted. Wraps modulo 2^AW.
  assign burst_bytes = ADDR_WIDTH'({1'b0, m_axi_awlen} + 1'b1) << 3;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values and the block order does not matter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= S_IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      beat_cnt      <= '0;
      burst_cnt     <= '0;
      wr_done       <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            m_axi_awaddr  <= wr_start_addr;
            m_axi_awlen   <= wr_burst_len - 1'b1;
            burst_cnt     <= wr_num_burst - 1'b1;
            beat_cnt      <= '0;
            m_axi_awvalid <= 1'b1;
            state         <= S_AW;
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            state         <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            if (m_axi_wlast) begin
              beat_cnt <= '0;
              state    <= S_B;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            if (burst_cnt == '0) begin
              wr_done <= 1'b1;
              state   <= S_DONE;
            end else begin
              burst_cnt     <= burst_cnt - 1'b1;
              m_axi_awaddr  <= m_axi_awaddr + burst_bytes;
              m_axi_awvalid <= 1'b1;
              state         <= S_AW;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WR_BRESP_CHECK_EN
  // Sticky error: a failed burst does not stop the command; the flag only
  // clears when a new command is taken.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_err <= 1'b0;
    end else if (start_ok) begin
      wr_err <= 1'b0;
    end else if ((state == S_B) && m_axi_bvalid && (m_axi_bresp != 2'b00)) begin
      wr_err <= 1'b1;
    end
  end
`else
  assign wr_err = 1'b0;
`endif

  // BID carries nothing this master needs (single fixed ID); BRESP is only
  // consumed when the error check is built in.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_bresp};

endmodule

// File: tb/tb_ddr_axi_write.sv
// ----------------------------------------------------------------------------
// tb_ddr_axi_write
//   Self-checking bench for ddr_axi_write. A slave/FIFO driver produces
//   randomised AXI ready/valid behaviour and an always-refilled FIFO holding
//   an incrementing sequence; a negedge monitor logs AW/W/B activity and a
//   command-level model predicts the burst addresses, lengths and beat counts.
// ----------------------------------------------------------------------------
module tb_ddr_axi_write;
  localparam int DW  = 64;
  localparam int AW  = 29;
  localparam int BLW = 8;
  localparam int NBW = 8;
`ifdef WR_BRESP_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           ACLK = 1'b0;
  logic           ARESETN;
  logic           wr_start;
  logic [BLW-1:0] wr_burst_len;
  logic [AW-1:0]  wr_start_addr;
  logic [NBW-1:0] wr_num_burst;
  logic           wr_ready;
  logic [DW-1:0]  wr_fifo_data;
  logic           wr_fifo_empty;
  logic           wr_fifo_re;
  logic           wr_done;
  logic           wr_err;
  logic [3:0]     m_axi_awid;
  logic [AW-1:0]  m_axi_awaddr;
  logic [BLW-1:0] m_axi_awlen;
  logic [2:0]     m_axi_awsize;
  logic [1:0]     m_axi_awburst;
  logic           m_axi_awlock;
  logic [3:0]     m_axi_awcache;
  logic [2:0]     m_axi_awprot;
  logic [3:0]     m_axi_awqos;
  logic           m_axi_awvalid;
  logic           m_axi_awready;
  logic [DW-1:0]  m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic           m_axi_wlast;
  logic           m_axi_wvalid;
  logic           m_axi_wready;
  logic [3:0]     m_axi_bid;
  logic [1:0]     m_axi_bresp;
  logic           m_axi_bvalid;
  logic           m_axi_bready;

  always #5 ACLK = ~ACLK;

  ddr_axi_write #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN_WIDTH(BLW), .NUM_BURST_WIDTH(NBW)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wr_start(wr_start), .wr_burst_len(wr_burst_len), .wr_start_addr(wr_start_addr),
    .wr_num_burst(wr_num_burst), .wr_ready(wr_ready),
    .wr_fifo_data(wr_fifo_data), .wr_fifo_empty(wr_fifo_empty), .wr_fifo_re(wr_fifo_re),
    .wr_done(wr_done), .wr_err(wr_err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // slave / FIFO knobs
  int aw_rate = 100, w_rate = 100, b_rate = 100, empty_rate = 0;
  int aw_hold = 0, empty_hold = 0, empty_at_beat = -1, err_burst = -1;

  // shared bench state
  logic [63:0]   fifo_q[$];
  logic [63:0]   data_ctr = 64'd1;
  logic [63:0]   exp_seq  = 64'd1;
  logic [AW-1:0] aw_addr_log[$];
  logic [BLW-1:0] aw_len_log[$];
  int   beats, wlast_cnt, done_cnt, beat_in_burst, cur_len, b_idx, aw_wait;
  int   cyc = 0, last_b_cyc = -10;
  bit   hs_w, hs_wlast, hs_b, b_pending;
  bit   prev_aw_wait;
  logic [AW-1:0]  prev_awaddr;
  logic [BLW-1:0] prev_awlen;
  logic err_at_done;

  // Slave and FIFO driver: updates inputs 1 ns after each rising edge.
  initial begin : slave_drv
    logic [63:0] tmp;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00; m_axi_bid = 4'hF; wr_fifo_empty = 1'b1; wr_fifo_data = '0;
    forever begin
      @(posedge ACLK); #1;
      if (hs_w) tmp = fifo_q.pop_front();
      if (hs_wlast) b_pending = 1'b1;
      if (hs_b) begin m_axi_bvalid = 1'b0; b_pending = 1'b0; b_idx++; end
      while (fifo_q.size() < 4) begin fifo_q.push_back(data_ctr); data_ctr++; end
      wr_fifo_data = fifo_q[0];
      if (empty_hold > 0 && empty_at_beat >= 0 && beats >= empty_at_beat) begin
        wr_fifo_empty = 1'b1; empty_hold--;
      end else begin
        wr_fifo_empty = ($urandom_range(0, 99) < empty_rate);
      end
      if (aw_hold > 0 && m_axi_awvalid) begin
        m_axi_awready = 1'b0; aw_hold--;
      end else begin
        m_axi_awready = ($urandom_range(0, 99) < aw_rate);
      end
      m_axi_wready = ($urandom_range(0, 99) < w_rate);
      if (b_pending && !m_axi_bvalid) m_axi_bvalid = ($urandom_range(0, 99) < b_rate);
      m_axi_bresp = (b_idx == err_burst) ? 2'b10 : 2'b00;
    end
  end

  // Monitor: at each falling edge, decides what will handshake on the next rise.
  initial begin : monitor
    forever begin
      @(negedge ACLK);
      cyc++;
      hs_w = 1'b0; hs_wlast = 1'b0; hs_b = 1'b0;
      if (ARESETN) begin
        if (m_axi_wvalid || wr_fifo_re)
          check("fifo_re_is_handshake", wr_fifo_re, m_axi_wvalid & m_axi_wready);
        if (wr_fifo_empty) check("wvalid_while_empty", m_axi_wvalid, 1'b0);
        if (m_axi_awvalid) check("aw_w_overlap", m_axi_wvalid, 1'b0);
        if (prev_aw_wait && m_axi_awvalid) begin
          check("awaddr_stable", m_axi_awaddr, prev_awaddr);
          check("awlen_stable", m_axi_awlen, prev_awlen);
        end
        prev_aw_wait = m_axi_awvalid && !m_axi_awready;
        if (prev_aw_wait) aw_wait++;
        prev_awaddr = m_axi_awaddr;
        prev_awlen  = m_axi_awlen;
        if (m_axi_awvalid && m_axi_awready) begin
          aw_addr_log.push_back(m_axi_awaddr);
          aw_len_log.push_back(m_axi_awlen);
          check("aw_consts", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                              m_axi_awcache, m_axi_awprot, m_axi_awqos},
                {4'hF, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0});
        end
        if (m_axi_wvalid && m_axi_wready) begin
          hs_w = 1'b1;
          beats++;
          check("wdata_seq", m_axi_wdata, exp_seq);
          exp_seq++;
          check("wstrb", m_axi_wstrb, 8'hFF);
          check("wlast", m_axi_wlast, beat_in_burst == cur_len - 1);
          if (beat_in_burst == cur_len - 1) begin
            hs_wlast = 1'b1; wlast_cnt++; beat_in_burst = 0;
          end else begin
            beat_in_burst++;
          end
        end
        if (m_axi_bvalid) begin
          check("bready", m_axi_bready, 1'b1);
          hs_b = 1'b1;
          last_b_cyc = cyc;
        end
        if (wr_done) begin
          done_cnt++;
          check("done_one_cycle_after_b", cyc, last_b_cyc + 1);
          err_at_done = wr_err;
        end
      end else begin
        prev_aw_wait = 1'b0;
      end
    end
  end

  task automatic clear_logs(input int len);
    aw_addr_log.delete(); aw_len_log.delete();
    beats = 0; wlast_cnt = 0; done_cnt = 0; beat_in_burst = 0;
    b_idx = 0; aw_wait = 0; cur_len = len;
  endtask

  task automatic pulse_start(input logic [AW-1:0] addr, input int len, input int num);
    wr_start = 1'b1; wr_start_addr = addr;
    wr_burst_len = BLW'(len); wr_num_burst = NBW'(num);
    @(posedge ACLK); #1;
    wr_start = 1'b0;
  endtask

  // Runs one command to completion and checks it against the command model.
  task automatic run_cmd(input logic [AW-1:0] addr, input int len, input int num,
                         input bit busy_poke, input bit exp_err,
                         output int n_beats, output logic [AW-1:0] last_addr);
    int t;
    logic [AW-1:0] exp_a;
    clear_logs(len);
    t = 0;
    while (!wr_ready && t < 100) begin @(posedge ACLK); #1; t++; end
    pulse_start(addr, len, num);
    check("ready_low_after_accept", wr_ready, 1'b0);
    check("err_clear_on_accept", wr_err, 1'b0);
    if (busy_poke) begin
      repeat (3) @(posedge ACLK);
      #1;
      check("busy_ready_low", wr_ready, 1'b0);
      pulse_start(AW'(32'h0ABC0), 2, 1);
    end
    t = 0;
    while (done_cnt == 0 && t < 6000) begin @(posedge ACLK); t++; end
    check("done_within_budget", t < 6000, 1'b1);
    repeat (4) @(posedge ACLK);
    #1;
    check("aw_count", aw_addr_log.size(), num);
    for (int i = 0; i < num && i < aw_addr_log.size(); i++) begin
      exp_a = addr + AW'(i * len * 8);
      check("aw_addr", aw_addr_log[i], exp_a);
      check("aw_len", aw_len_log[i], len - 1);
    end
    check("beat_count", beats, len * num);
    check("wlast_count", wlast_cnt, num);
    check("done_count", done_cnt, 1);
    check("err_at_done", err_at_done, exp_err);
    check("ready_after_cmd", wr_ready, 1'b1);
    n_beats = beats;
    last_addr = (aw_addr_log.size() > 0) ? aw_addr_log[aw_addr_log.size() - 1] : '1;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    int            num;
    int            exp_beats;
    logic [AW-1:0] exp_last;
  } vec_t;

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[6];
    int nb;
    logic [AW-1:0] la;
    vecs[0] = '{AW'(32'h100),        4,   1, 4,   AW'(32'h100)};
    vecs[1] = '{AW'(32'h1000),       8,   3, 24,  AW'(32'h1080)};
    vecs[2] = '{AW'(32'h2000),       1,   1, 1,   AW'(32'h2000)};
    vecs[3] = '{AW'(32'h3000),       255, 1, 255, AW'(32'h3000)};
    vecs[4] = '{AW'(32'h1FFFFFC0),   8,   2, 16,  AW'(32'h0)};
    vecs[5] = '{AW'(32'h4000),       1, 255, 255, AW'(32'h47F0)};

    ARESETN = 1'b0; wr_start = 1'b0; wr_start_addr = '0; wr_burst_len = '0; wr_num_burst = '0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_ready", wr_ready, 1'b1);
    check("rst_awvalid", m_axi_awvalid, 1'b0);
    check("rst_awaddr", m_axi_awaddr, '0);
    check("rst_awlen", m_axi_awlen, '0);
    check("rst_wvalid", m_axi_wvalid, 1'b0);
    check("rst_wlast", m_axi_wlast, 1'b0);
    check("rst_fifo_re", wr_fifo_re, 1'b0);
    check("rst_done", wr_done, 1'b0);
    check("rst_err", wr_err, 1'b0);
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;

    // table-driven commands, slave always ready
    foreach (vecs[i]) begin
      run_cmd(vecs[i].addr, vecs[i].len, vecs[i].num, 1'b0, 1'b0, nb, la);
      check("tbl_beats", nb, vecs[i].exp_beats);
      check("tbl_last_addr", la, vecs[i].exp_last);
    end

    // zero-length / zero-count commands are ignored
    clear_logs(1);
    pulse_start(AW'(32'h800), 0, 3);
    check("len0_ready", wr_ready, 1'b1);
    pulse_start(AW'(32'h800), 4, 0);
    repeat (5) @(posedge ACLK);
    #1;
    check("zero_cmd_ready", wr_ready, 1'b1);
    check("zero_cmd_no_aw", aw_addr_log.size(), 0);

    // start while busy does not disturb the active command
    run_cmd(AW'(32'h6000), 8, 3, 1'b1, 1'b0, nb, la);

    // AW stall, toggling wready, FIFO empty mid-burst
    aw_hold = 5; w_rate = 50; empty_at_beat = 2; empty_hold = 3;
    run_cmd(AW'(32'h5000), 8, 2, 1'b0, 1'b0, nb, la);
    check("aw_stall_seen", aw_wait >= 5, 1'b1);
    w_rate = 100; empty_at_beat = -1; empty_hold = 0; aw_hold = 0;

    // error response on the first burst; then cleared by the next command
    err_burst = 0;
    run_cmd(AW'(32'h7000), 4, 2, 1'b0, ERR_EN, nb, la);
    check("err_sticky_after_done", wr_err, ERR_EN);
    err_burst = -1;
    run_cmd(AW'(32'h7100), 2, 1, 1'b0, 1'b0, nb, la);

    // reset during beat 3 of 8
    clear_logs(8);
    pulse_start(AW'(32'h8000), 8, 1);
    for (int t = 0; t < 200 && beats < 2; t++) @(negedge ACLK);
    check("reached_beat3", beats, 2);
    @(posedge ACLK); #3;
    ARESETN = 1'b0;
    #1;
    hs_w = 1'b0; hs_wlast = 1'b0; hs_b = 1'b0; b_pending = 1'b0; m_axi_bvalid = 1'b0;
    check("rst_mid_awvalid", m_axi_awvalid, 1'b0);
    check("rst_mid_wvalid", m_axi_wvalid, 1'b0);
    check("rst_mid_wlast", m_axi_wlast, 1'b0);
    check("rst_mid_ready", wr_ready, 1'b1);
    repeat (2) @(posedge ACLK);
    fifo_q.delete();
    exp_seq = data_ctr;
    #2;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("post_rst_ready", wr_ready, 1'b1);
    check("post_rst_awaddr", m_axi_awaddr, '0);
    run_cmd(AW'(32'h9000), 4, 2, 1'b0, 1'b0, nb, la);

    // randomised commands and slave behaviour
    for (int k = 0; k < 20; k++) begin
      aw_rate = $urandom_range(30, 100);
      w_rate  = $urandom_range(30, 100);
      b_rate  = $urandom_range(30, 100);
      empty_rate = $urandom_range(0, 40);
      run_cmd(AW'({$urandom} << 3), $urandom_range(1, 16), $urandom_range(1, 4),
              1'b0, 1'b0, nb, la);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
